// File: rtl/serial_fadder.sv
// serial_fadder: bit-serial WIDTH-bit adder/subtractor.
// One full-adder cell, registered carry, start/busy/done handshake.
module serial_fadder #(
    parameter int WIDTH     = 8,
    parameter bit INVERT_IN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Board inputs may be active-low; normalise them once at the pins.
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sub_in;

    assign a_in   = INVERT_IN ? ~a : a;
    assign b_in   = INVERT_IN ? ~b : b;
    assign sub_in = INVERT_IN ? ~sub : sub;

    // The single full-adder cell working on the LSBs.
    logic s_bit;
    logic c_nx;
    logic last;

    assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nx  = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & c_q);
    assign last  = (cnt_q == CW'(WIDTH - 1));

    // Next-state, datapath shifting and result loading.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = sub_in ? ~b_in : b_in;
                    c_d     = sub_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = {s_bit, r_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = c_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    // c_q here is the carry into the MSB.
                    sum_d   = {s_bit, r_q[WIDTH-1:1]};
                    cout_d  = c_nx;
                    ovf_d   = c_q ^ c_nx;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_fadder.sv
// tb_serial_fadder: directed + random checks of serial_fadder.
// Two instances: active-high inputs and active-low inputs.
module tb_serial_fadder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub0, sub1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         busy0, done0, cout0, ovf0;
    logic         busy1, done1, cout1, ovf1;
    logic [W-1:0] sum0, sum1;

    int n_vec;
    int n_err;

    logic [W-1:0] opa [0:3];
    logic [W-1:0] opb [0:3];
    logic         ops [0:3];

    serial_fadder #(.WIDTH(W), .INVERT_IN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .sub(sub0),
        .a(a0), .b(b0), .busy(busy0), .done(done0),
        .sum(sum0), .cout(cout0), .ovf(ovf0)
    );

    serial_fadder #(.WIDTH(W), .INVERT_IN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub1),
        .a(a1), .b(b1), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic s);
        int ux, uy, sx, sy, u, r;
        logic [W-1:0] se;
        logic ce, oe;
        ux = int'(x);
        uy = int'(y);
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            u  = ux - uy;
            ce = (ux >= uy);
            r  = sx - sy;
        end else begin
            u  = ux + uy;
            ce = (u > 255);
            r  = sx + sy;
        end
        se = u[W-1:0];
        oe = (r > 127) || (r < -128);
        return {oe, ce, se};
    endfunction

    task automatic drive(input int k);
        a0   = opa[k];
        b0   = opb[k];
        sub0 = ops[k];
        a1   = ~opa[k];
        b1   = ~opb[k];
        sub1 = ~ops[k];
    endtask

    task automatic drive_rand();
        a0   = 8'($urandom);
        b0   = 8'($urandom);
        sub0 = 1'($urandom);
        a1   = 8'($urandom);
        b1   = 8'($urandom);
        sub1 = 1'($urandom);
    endtask

    task automatic chk_hs(input string tag, input logic eb, input logic ed);
        chk({tag, "_busy0"}, 32'(busy0), 32'(eb));
        chk({tag, "_done0"}, 32'(done0), 32'(ed));
        chk({tag, "_busy1"}, 32'(busy1), 32'(eb));
        chk({tag, "_done1"}, 32'(done1), 32'(ed));
    endtask

    task automatic chk_res(input string tag, input logic [W+1:0] e);
        chk({tag, "_sum0"},  32'(sum0),  32'(e[W-1:0]));
        chk({tag, "_cout0"}, 32'(cout0), 32'(e[W]));
        chk({tag, "_ovf0"},  32'(ovf0),  32'(e[W+1]));
        chk({tag, "_sum1"},  32'(sum1),  32'(e[W-1:0]));
        chk({tag, "_cout1"}, 32'(cout1), 32'(e[W]));
        chk({tag, "_ovf1"},  32'(ovf1),  32'(e[W+1]));
    endtask

    // Run n operations from opa/opb/ops; hold keeps start high
    // between them, repulse pokes start mid-RUN with junk operands.
    task automatic run(input int n, input bit hold, input bit repulse);
        bit keep;
        @(negedge clk);
        drive(0);
        start = 1'b1;
        for (int k = 0; k < n; k++) begin
            keep = hold && (k + 1 < n);
            @(negedge clk);
            start = keep;
            if (keep) drive(k + 1);
            else drive_rand();
            chk_hs("run_c0", 1'b1, 1'b0);
            for (int i = 1; i < W; i++) begin
                @(negedge clk);
                chk_hs("run_busy", 1'b1, 1'b0);
                if (repulse && i == 3) begin
                    start = 1'b1;
                    drive_rand();
                end else begin
                    start = keep;
                end
            end
            @(negedge clk);
            chk_hs("run_done", 1'b0, 1'b1);
            chk_res("res", model(opa[k], opb[k], ops[k]));
        end
        @(negedge clk);
        chk_hs("run_idle", 1'b0, 1'b0);
    endtask

    task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic s, input bit repulse);
        opa[0] = x;
        opb[0] = y;
        ops[0] = s;
        run(1, 1'b0, repulse);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        drive_rand();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk_hs("reset", 1'b0, 1'b0);
        chk_res("reset", '0);
        start = 1'b0;
        rst   = 1'b0;

        run_one(8'h5A, 8'h3C, 1'b0, 1'b0);
        run_one(8'hFF, 8'h01, 1'b0, 1'b0);
        run_one(8'h10, 8'h20, 1'b1, 1'b0);
        run_one(8'h80, 8'h01, 1'b1, 1'b0);
        run_one(8'h03, 8'h04, 1'b0, 1'b0);

        run_one(8'h7F, 8'h7F, 1'b0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            opa[k] = 8'($urandom);
            opb[k] = 8'($urandom);
            ops[k] = 1'($urandom);
        end
        run(4, 1'b1, 1'b0);

        for (int j = 0; j < 20; j++) begin
            run_one(8'($urandom), 8'($urandom), 1'($urandom),
                    bit'($urandom_range(0, 3) == 0));
        end

        run_one(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        drive(0);
        opa[0] = 8'h21;
        opb[0] = 8'h12;
        ops[0] = 1'b0;
        drive(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_rand();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_hs("midrst", 1'b0, 1'b0);
        chk_res("midrst", '0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            chk_hs("midrst_quiet", 1'b0, 1'b0);
        end
        chk_res("midrst_hold", '0);

        run_one(8'hC3, 8'h5D, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_fadder.md
# serial_fadder

Parametrised bit-serial adder/subtractor: WIDTH-bit operands are summed one bit per clock through a single full-adder cell with a registered carry. It is the multi-bit successor to the board-level one-bit full adder. It sits between push-button/DIP operand capture and the LED/seven-segment display logic, trading latency for minimal LUT use. Adds subtract mode, a start/busy/done handshake and carry/overflow flags.

## Interface

Parameters:
- WIDTH, default 8, operand and result width in bits; legal range 2..32.
- INVERT_IN, default 1. When 1, `a`, `b` and `sub` are active-low board inputs and are inverted at capture. When 0, they are used as-is.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is ready (IDLE or DONE).
- sub  input  1  operation select, after INVERT_IN: 0 = A+B, 1 = A−B.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a result is loaded.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  two's-complement signed overflow.

## Operation

- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **Accept (IDLE or DONE with start=1):**
  - Capture A = a and B = b, and latch the operation select; all three are inverted first if INVERT_IN=1.
  - If subtracting: the B shift register receives ~B and carry is preset to 1. If adding: carry is preset to 0.
  - Bit counter is cleared to 0. Go to RUN.
- **RUN, every cycle:**
  - s = A[0]^B[0]^c and c' = (A[0]&B[0]) | ((A[0]^B[0])&c).
  - s shifts into the MSB of the result shift register. A and B shift right by one. The carry register takes c'.
  - Before the MSB step, the carry-in to the MSB is recorded for ovf.
  - Counter increments. On the step with counter = WIDTH−1:
    - sum ← the final shifted result.
    - cout ← c'.
    - ovf ← (MSB carry-in) ^ c'.
    - Go to DONE.
- **DONE:** done = 1 for exactly this cycle.
  - With start=1, accept a new operation (back-to-back).
  - Otherwise go to IDLE.
- start in RUN is ignored; no queueing.
- Operand inputs change freely outside the accepting edge without effect.
- Arithmetic is modulo 2^WIDTH; sum never grows beyond WIDTH bits.
- Counter width is $clog2(WIDTH).

## Timing

- **Reset values:**
  - Outputs: busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal: FSM=IDLE, shift registers, carry and counter all 0.
- Reset has priority over every other event, including start on the same edge.
- **Latency:** start accepted at edge E0.
  - busy is high from E0 through E0+WIDTH.
  - sum, cout and ovf update at edge E0+WIDTH.
  - done is high in the cycle between edges E0+WIDTH and E0+WIDTH+1.
- **Throughput:** one result per WIDTH+1 cycles when start is held high or re-asserted in DONE. It is WIDTH+2 cycles if start returns only in IDLE.
- **Reset mid-RUN:** the operation is abandoned. No done pulse. sum, cout and ovf clear to 0.
- No combinational path from any input to any output.

## Test plan

- **Signed-overflow add:** WIDTH=8, INVERT_IN=0, sub=0, a=0x5A, b=0x3C, start pulse.
  - Required: sum=0x96, cout=0, ovf=1.
  - done pulses exactly 8 cycles after the accepting edge; busy is high for 8 cycles.
- **Unsigned carry-out add:** a=0xFF, b=0x01, sub=0 → sum=0x00, cout=1, ovf=0.
- **Subtract:** INVERT_IN=0.
  - a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0 (borrow), ovf=0.
  - Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
- **Active-low inputs:** INVERT_IN=1, a=0xFC, b=0xFB, sub=1 (add), start → sum=0x07, cout=0, ovf=0.
- **Handshake abuse:**
  - start re-pulsed mid-RUN with different operands → ignored; first result is correct.
  - start held high → results every 9 cycles, one done pulse per result.
- **Reset mid-operation:** rst asserted 3 cycles after start for 1 cycle.
  - Required: busy=0, done never pulses, sum=0, cout=0, ovf=0.
  - A fresh start afterwards yields the correct result.
